button_debounce: RTL

- Front-end conditioning stage for the single-tick start generator; its press_o drives that block's button_i.
- Synchronises a raw, asynchronous push-button into the clk_i domain and rejects bounce shorter than a programmable stable time of k_i cycles.
- Produces a clean debounced level plus one-cycle press and release pulses.

---
 rtl/button_debounce_if.sv | 30 +++
 rtl/button_debounce.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/button_debounce_if.sv
// Signal bundle between a push-button debouncer and its consumer.
// The debouncer takes the slave side; the driver of k_i/button_i takes the master side.
interface button_debounce_if #(
  parameter int unsigned Width = 30
);
  logic [Width-1:0] k_i;
  logic             button_i;
  logic             level_o;
  logic             press_o;
  logic             release_o;
  logic             busy_o;

  modport master (
    output k_i,
    output button_i,
    input  level_o,
    input  press_o,
    input  release_o,
    input  busy_o
  );

  modport slave (
    input  k_i,
    input  button_i,
    output level_o,
    output press_o,
    output release_o,
    output busy_o
  );
endinterface

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronises a raw button, accepts a level change only after it has
// been stable for k_i samples, and emits one-cycle press/release pulses.
module button_debounce #(
  parameter int unsigned Width      = 30,
  parameter int unsigned SyncStages = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  button_debounce_if.slave  bus_io
);

  typedef enum logic [1:0] {
    StLow,
    StWaitH,
    StHigh,
    StWaitL
  } state_e;

  logic [SyncStages-1:0] sync_q;
  logic                  s;

  state_e           state_q;
  logic [Width-1:0] cnt_q;
  logic [Width-1:0] k_lat_q;
  logic             level_q;
  logic             press_q;
  logic             release_q;
  logic             busy_q;

  logic [Width-1:0] k;
  logic             k_short;
  logic [Width-1:0] cnt_inc;
  logic             cnt_done;

  // Synchroniser chain; only its last stage feeds the FSM.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], bus_io.button_i};
    end
  end

  assign s        = sync_q[SyncStages-1];
  assign k        = bus_io.k_i;
  assign k_short  = (k <= Width'(1));
  assign cnt_inc  = cnt_q + Width'(1);
  // cnt_q stays below k_lat_q, so cnt_inc cannot wrap even with k_lat_q all-ones.
  assign cnt_done = (cnt_inc == k_lat_q);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StLow;
      cnt_q     <= '0;
      k_lat_q   <= Width'(1);
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      case (state_q)
        StLow: begin
          if (s) begin
            if (k_short) begin
              state_q <= StHigh;
              level_q <= 1'b1;
              press_q <= 1'b1;
            end else begin
              k_lat_q <= k;
              cnt_q   <= Width'(1);
              state_q <= StWaitH;
              busy_q  <= 1'b1;
            end
          end
        end
        StWaitH: begin
          if (!s) begin
            state_q <= StLow;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_done) begin
            state_q <= StHigh;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StHigh: begin
          if (!s) begin
            if (k_short) begin
              state_q   <= StLow;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              k_lat_q <= k;
              cnt_q   <= Width'(1);
              state_q <= StWaitL;
              busy_q  <= 1'b1;
            end
          end
        end
        StWaitL: begin
          if (s) begin
            state_q <= StHigh;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else if (cnt_done) begin
            state_q   <= StLow;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            release_q <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        default: begin
          state_q <= StLow;
          cnt_q   <= '0;
          level_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus_io.level_o   = level_q;
  assign bus_io.press_o   = press_q;
  assign bus_io.release_o = release_q;
  assign bus_io.busy_o    = busy_q;

`ifndef SYNTHESIS
  pulses_exclusive_a: assert property (@(posedge clk_i) disable iff (!rst_i)
    !(press_q && release_q));
  press_single_a: assert property (@(posedge clk_i) disable iff (!rst_i)
    press_q |=> !press_q);
  release_single_a: assert property (@(posedge clk_i) disable iff (!rst_i)
    release_q |=> !release_q);
  cnt_bounded_a: assert property (@(posedge clk_i) disable iff (!rst_i)
    busy_q |-> (cnt_q < k_lat_q));
`endif

endmodule
